// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port (fetch / load-store) arbiter in front of the data RAM
// Optional feature macro: MEM_ARB_RR_EN (round-robin tie-break instead of fixed DATA_PRIO)
module mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter bit DATA_PRIO = 1'b1
) (
  input  logic              clka,
  input  logic              rstn,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [2:0]        d_size,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  output logic [2:0]        ram_u_b_h_w,
  input  logic [31:0]       ram_dout
);

  typedef enum logic {S_IDLE, S_ACCESS} state_e;

  localparam logic [2:0] SIZE_WORD = 3'b010;

  state_e            state_q, state_d;
  logic              own_d_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        size_q;
  logic              if_rvalid_q, d_rvalid_q, if_err_q, d_err_q;
  logic [31:0]       if_rdata_q, d_rdata_q;
  logic              if_wins_tie;
  logic              misaligned;

`ifdef MEM_ARB_RR_EN
  logic last_d_q;

  // Remember which port was granted last; starts as "IF last" so D wins the first tie
  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn)       last_d_q <= 1'b0;
    else if (if_gnt) last_d_q <= 1'b0;
    else if (d_gnt)  last_d_q <= 1'b1;
  end

  assign if_wins_tie = last_d_q;
`else
  assign if_wins_tie = ~DATA_PRIO;
`endif

  // State register
  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and combinational grant: at most one port granted, only while idle
  always_comb begin
    state_d = state_q;
    if_gnt  = 1'b0;
    d_gnt   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (if_req && (!d_req || if_wins_tie)) if_gnt = 1'b1;
        else if (d_req)                        d_gnt  = 1'b1;
        if (if_gnt || d_gnt) state_d = S_ACCESS;
      end
      S_ACCESS: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Capture the granted request; fetches are always word reads
  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      own_d_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= SIZE_WORD;
    end else if (if_gnt) begin
      own_d_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= if_addr;
      wdata_q <= '0;
      size_q  <= SIZE_WORD;
    end else if (d_gnt) begin
      own_d_q <= 1'b1;
      we_q    <= d_we;
      addr_q  <= d_addr;
      wdata_q <= d_wdata;
      size_q  <= d_size;
    end
  end

  // Word needs 4-byte alignment, half needs 2-byte; bytes are always aligned
  always_comb begin
    misaligned = 1'b0;
    if (size_q[1])      misaligned = (addr_q[1:0] != 2'b00);
    else if (size_q[0]) misaligned = addr_q[0];
  end

  // Drive the RAM only during the access slot; a misaligned store never writes
  always_comb begin
    ram_addr    = '0;
    ram_din     = '0;
    ram_we      = 1'b0;
    ram_u_b_h_w = SIZE_WORD;
    if (state_q == S_ACCESS) begin
      ram_addr    = addr_q;
      ram_din     = wdata_q;
      ram_we      = we_q & ~misaligned;
      ram_u_b_h_w = size_q;
    end
  end

  // Registered response to the owning port at the end of the access slot
  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_err_q    <= 1'b0;
      d_err_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_err_q    <= 1'b0;
      d_err_q     <= 1'b0;
      if (state_q == S_ACCESS) begin
        if (own_d_q) begin
          d_rvalid_q <= 1'b1;
          d_err_q    <= misaligned;
          d_rdata_q  <= (we_q || misaligned) ? 32'd0 : ram_dout;
        end else begin
          if_rvalid_q <= 1'b1;
          if_err_q    <= misaligned;
          if_rdata_q  <= misaligned ? 32'd0 : ram_dout;
        end
      end
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign if_err    = if_err_q;
  assign if_rdata  = if_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter with RAM and reference model
module tb_mem_port_arbiter;

  logic        clka = 1'b0;
  logic        rstn = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [2:0]  d_size = 3'b010;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic [31:0] ram_addr, ram_din;
  logic        ram_we;
  logic [2:0]  ram_u_b_h_w;
  logic [31:0] ram_dout;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int we_count = 0;

  logic [7:0] ram_mem [256];
  logic [7:0] ref_mem [256];

  mem_port_arbiter #(.ADDR_W(32), .DATA_PRIO(1'b1)) dut (
    .clka(clka), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_u_b_h_w(ram_u_b_h_w), .ram_dout(ram_dout)
  );

  always #5 clka = ~clka;

  always @(posedge clka) cyc <= cyc + 1;

  // Simulation RAM: combinational read, commit on the falling edge
  always_comb begin
    logic [7:0] b0, b1, b2, b3;
    b0 = ram_mem[ram_addr[7:0]];
    b1 = ram_mem[8'(ram_addr[7:0] + 8'd1)];
    b2 = ram_mem[8'(ram_addr[7:0] + 8'd2)];
    b3 = ram_mem[8'(ram_addr[7:0] + 8'd3)];
    ram_dout = '0;
    if (ram_u_b_h_w[1])      ram_dout = {b3, b2, b1, b0};
    else if (ram_u_b_h_w[0]) ram_dout = {{16{~ram_u_b_h_w[2] & b1[7]}}, b1, b0};
    else                     ram_dout = {{24{~ram_u_b_h_w[2] & b0[7]}}, b0};
  end

  always @(negedge clka) begin
    if (ram_we === 1'b1) begin
      we_count = we_count + 1;
      ram_mem[ram_addr[7:0]] = ram_din[7:0];
      if (ram_u_b_h_w[1] || ram_u_b_h_w[0])
        ram_mem[8'(ram_addr[7:0] + 8'd1)] = ram_din[15:8];
      if (ram_u_b_h_w[1]) begin
        ram_mem[8'(ram_addr[7:0] + 8'd2)] = ram_din[23:16];
        ram_mem[8'(ram_addr[7:0] + 8'd3)] = ram_din[31:24];
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] sz);
    return sz[1] ? 4 : (sz[0] ? 2 : 1);
  endfunction

  function automatic logic model_misal(input logic [31:0] addr, input logic [2:0] sz);
    return (addr % nbytes(sz)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] sz);
    longint v;
    int n;
    n = nbytes(sz);
    v = 0;
    for (int i = 0; i < n; i++) v = v + (longint'(ref_mem[(addr + i) % 256]) << (8 * i));
    if (!sz[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] sz);
    for (int i = 0; i < nbytes(sz); i++) ref_mem[(addr + i) % 256] = 8'(data >> (8 * i));
  endtask

  task automatic poke(input int a, input logic [7:0] b);
    ram_mem[a % 256] = b;
    ref_mem[a % 256] = b;
  endtask

  // One request on the chosen port; returns response plus grant and response cycles
  task automatic access(input bit is_d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] sz,
                        output logic [31:0] rd, output logic err, output int gc, output int rc);
    bit got, seen;
    rd = '0; err = 1'b0; gc = -1; rc = -1; got = 0; seen = 0;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_size = sz;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int n = 0; n < 8 && !got; n++) begin
      @(negedge clka);
      if ((is_d ? d_gnt : if_gnt) === 1'b1) begin got = 1; gc = cyc; end
      @(posedge clka); #1;
    end
    d_req = 1'b0; if_req = 1'b0;
    chk("gnt_seen", 32'(got), 32'd1);
    for (int n = 0; n < 4 && got && !seen; n++) begin
      if ((is_d ? d_rvalid : if_rvalid) === 1'b1) begin
        seen = 1; rc = cyc;
        rd  = is_d ? d_rdata : if_rdata;
        err = is_d ? d_err : if_err;
        chk("other_rvalid_idle", 32'(is_d ? if_rvalid : d_rvalid), 32'd0);
      end else begin
        chk("err_without_rvalid", 32'(is_d ? d_err : if_err), 32'd0);
        @(posedge clka); #1;
      end
    end
    if (got) chk("rvalid_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    logic [31:0] rd, rd2, exp;
    logic        err;
    int          gc, rc, gc2, rc2, wc0;
    logic [11:0] gnt_hist, gnt_exp;
    bit          is_d, we;
    logic [31:0] addr, wdata;
    logic [2:0]  sz;
    logic [2:0]  sizes [5];

    for (int i = 0; i < 256; i++) poke(i, 8'($urandom));

    // Reset state
    #2 rstn = 1'b0;
    repeat (2) @(posedge clka);
    #1;
    chk("rst_if_gnt", 32'(if_gnt), 32'd0);
    chk("rst_d_gnt", 32'(d_gnt), 32'd0);
    chk("rst_rvalids", 32'({if_rvalid, d_rvalid, if_err, d_err}), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_ram_din", ram_din, 32'd0);
    chk("rst_ram_size", 32'(ram_u_b_h_w), 32'd2);
    rstn = 1'b1;
    @(posedge clka); #1;

    // Fetch of word 0x04
    poke(4, 8'h11); poke(5, 8'h22); poke(6, 8'h33); poke(7, 8'h44);
    access(0, 0, 32'h04, 32'h0, 3'b010, rd, err, gc, rc);
    chk("fetch_data", rd, 32'h44332211);
    chk("fetch_err", 32'(err), 32'd0);
    chk("fetch_latency", 32'(rc - gc), 32'd2);

    // Word store then signed byte load
    wc0 = we_count;
    access(1, 1, 32'h10, 32'hDEADBEEF, 3'b010, rd, err, gc, rc);
    model_store(32'h10, 32'hDEADBEEF, 3'b010);
    chk("store_rdata", rd, 32'd0);
    chk("store_err", 32'(err), 32'd0);
    chk("store_we_pulses", 32'(we_count - wc0), 32'd1);
    wc0 = we_count;
    access(1, 0, 32'h13, 32'h0, 3'b000, rd, err, gc, rc);
    chk("lb_data", rd, 32'hFFFFFFDE);
    chk("lb_no_write", 32'(we_count - wc0), 32'd0);

    // Misaligned half store is blocked
    wc0 = we_count;
    access(1, 1, 32'h21, 32'h0000CAFE, 3'b001, rd, err, gc, rc);
    chk("mis_err", 32'(err), 32'd1);
    chk("mis_rdata", rd, 32'd0);
    chk("mis_no_write", 32'(we_count - wc0), 32'd0);
    access(1, 0, 32'h20, 32'h0, 3'b010, rd, err, gc, rc);
    chk("mis_word_after", rd, model_load(32'h20, 3'b010));

    // Reset during the access slot of a byte store
    poke(32'h30, 8'hA7);
    wc0 = we_count;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'h55; d_size = 3'b000;
    @(negedge clka);
    chk("rst_mid_gnt", 32'(d_gnt), 32'd1);
    @(posedge clka); #1;
    d_req = 1'b0;
    #1 rstn = 1'b0;
    #1;
    chk("rst_mid_ram_we", 32'(ram_we), 32'd0);
    chk("rst_mid_ram_addr", ram_addr, 32'd0);
    chk("rst_mid_ram_din", ram_din, 32'd0);
    chk("rst_mid_ram_size", 32'(ram_u_b_h_w), 32'd2);
    chk("rst_mid_d_rdata", d_rdata, 32'd0);
    chk("rst_mid_if_rdata", if_rdata, 32'd0);
    @(posedge clka); #1;
    chk("rst_mid_no_rvalid", 32'({d_rvalid, if_rvalid}), 32'd0);
    rstn = 1'b1;
    @(posedge clka); #1;
    chk("rst_mid_no_write", 32'(we_count - wc0), 32'd0);
    access(1, 0, 32'h30, 32'h0, 3'b100, rd, err, gc, rc);
    chk("rst_mid_load", rd, 32'h000000A7);

    // Simultaneous requests straight out of reset
    rstn = 1'b0;
    @(posedge clka); #1;
    rstn = 1'b1;
    if_req = 1'b1; if_addr = 32'h04;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; d_size = 3'b010;
    gnt_hist = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clka);
      gnt_hist[2*i +: 2] = {if_gnt, d_gnt};
      @(posedge clka); #1;
    end
    if_req = 1'b0; d_req = 1'b0;
`ifdef MEM_ARB_RR_EN
    gnt_exp = 12'b00_01_00_10_00_01;
`else
    gnt_exp = 12'b00_01_00_01_00_01;
`endif
    chk("tie_grant_order", 32'(gnt_hist), 32'(gnt_exp));
    repeat (3) @(posedge clka);
    #1;

    // Back-to-back loads
    poke(32'h42, 8'h80); poke(32'h43, 8'hFF);
    access(1, 0, 32'h40, 32'h0, 3'b010, rd, err, gc, rc);
    access(1, 0, 32'h42, 32'h0, 3'b101, rd2, err, gc2, rc2);
    chk("b2b_first", rd, model_load(32'h40, 3'b010));
    chk("b2b_overlap", 32'(gc2), 32'(rc));
    chk("b2b_second", rd2, 32'h0000FF80);

    // Randomized single-port traffic against the reference model
    sizes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int it = 0; it < 40; it++) begin
      is_d  = ($urandom_range(0, 3) != 0);
      we    = is_d && $urandom_range(0, 1);
      addr  = 32'($urandom_range(0, 255));
      wdata = $urandom;
      sz    = is_d ? sizes[$urandom_range(0, 4)] : 3'b010;
      wc0   = we_count;
      access(is_d, we, addr, wdata, sz, rd, err, gc, rc);
      exp = (we || model_misal(addr, sz)) ? 32'd0 : model_load(addr, sz);
      chk("rnd_err", 32'(err), 32'(model_misal(addr, sz)));
      chk("rnd_rdata", rd, exp);
      chk("rnd_latency", 32'(rc - gc), 32'd2);
      chk("rnd_writes", 32'(we_count - wc0), 32'(we && !model_misal(addr, sz)));
      if (we && !model_misal(addr, sz)) model_store(addr, wdata, sz);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
